// File: rtl/cdc_event_queue.sv
// Per-channel saturating event counters, replayed one at a time in round-robin order as fire_o requests to a crossing.
// evt_i to fire_o takes 2 cycles. While ready_i withholds service, events queue up; they drop and set the sticky overflow flag only at counter saturation.
module cdc_event_queue #(
  parameter int  CHANNELS = 4,
  parameter int  CNT_W    = 4,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [CHANNELS-1:0] evt_i,
  input  logic                ready_i,
  output logic                fire_o,
  output logic [CH_W-1:0]     fireCh_o,
  output logic [CHANNELS-1:0] pending_o,
  output logic [CHANNELS-1:0] overflow_o,
  input  logic [CHANNELS-1:0] overflowClr_i
);

  typedef enum logic [1:0] {IDLE, FIRE, WAIT} stateE;

  localparam logic [CNT_W-1:0] CntMax = '1;

  stateE               state;
  logic [CH_W-1:0]     last;
  logic [CH_W-1:0]     nextCh;
  logic [CH_W-1:0]     idx;
  logic                found;
  logic [CNT_W-1:0]    cnt [CHANNELS];
  logic [CHANNELS-1:0] dec;
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] ovfSet;

  assign fire_o = (state == FIRE);

  // An event coinciding with its own channel's fire cancels out, so it can never overflow.
  assign ovfSet = evt_i & ~dec & full;

  always_comb begin
    pending_o = '0;
    dec       = '0;
    full      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pending_o[c] = (cnt[c] != '0);
      full[c]      = (cnt[c] == CntMax);
      dec[c]       = fire_o && (fireCh_o == CH_W'(c));
    end
  end

  // Round-robin search starting just after the previously served channel.
  always_comb begin
    found  = 1'b0;
    nextCh = '0;
    idx    = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = CH_W'((int'(last) + i) % CHANNELS);
      if (!found && pending_o[idx]) begin
        found  = 1'b1;
        nextCh = idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c] <= '0;
      end
      overflow_o <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (evt_i[c] && !dec[c] && !full[c]) begin
          cnt[c] <= cnt[c] + 1'b1;
        end else if (dec[c] && !evt_i[c]) begin
          cnt[c] <= cnt[c] - 1'b1;
        end
      end
      overflow_o <= ovfSet | (overflow_o & ~overflowClr_i);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      fireCh_o <= '0;
      last     <= CH_W'(CHANNELS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (ready_i && found) begin
            state    <= FIRE;
            fireCh_o <= nextCh;
            last     <= nextCh;
          end
        end
        FIRE: state <= WAIT;
        // ready_i dropping is the crossing's acknowledge of the request.
        WAIT: begin
          if (!ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_event_queue.sv
// Directed bench for cdc_event_queue: queue-level reference model checked every cycle, plus literal expectations.
module tb_cdc_event_queue;

  localparam int CH   = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic [CH-1:0] evt_i;
  logic          ready_i;
  logic          fire_o;
  logic [1:0]    fireCh_o;
  logic [CH-1:0] pending_o;
  logic [CH-1:0] overflow_o;
  logic [CH-1:0] overflowClr_i;

  int nTests = 0;
  int nFail  = 0;
  int fireLog[$];

  // Reference model: pending counts, sticky flags, last served channel, request phase.
  int            mCnt[CH];
  logic [CH-1:0] mOvf;
  int            mLast;
  int            mFireCh;
  int            mPhase;

  // Downstream responder state.
  logic dsAuto;
  logic readyQ;
  logic prevFire;
  int   dsHold;

  always #5 clk = ~clk;

  cdc_event_queue #(.CHANNELS(CH), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .evt_i        (evt_i),
    .ready_i      (ready_i),
    .fire_o       (fire_o),
    .fireCh_o     (fireCh_o),
    .pending_o    (pending_o),
    .overflow_o   (overflow_o),
    .overflowClr_i(overflowClr_i)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare at the falling edge, then advance the model by one cycle.
  initial begin : cmp
    logic [CH-1:0] pend;
    bit            got;
    bit            inc;
    bit            dcr;
    bit            setNow;
    int            sel;
    int            ch;
    forever begin
      @(negedge clk);
      if (!rstn_i) begin
        for (int c = 0; c < CH; c++) mCnt[c] = 0;
        mOvf    = '0;
        mLast   = CH - 1;
        mFireCh = 0;
        mPhase  = 0;
      end
      pend = '0;
      for (int c = 0; c < CH; c++) pend[c] = (mCnt[c] != 0);
      chk("model fire_o", int'(fire_o), (mPhase == 1) ? 1 : 0);
      chk("model fireCh_o", int'(fireCh_o), mFireCh);
      chk("model pending_o", int'(pending_o), int'(pend));
      chk("model overflow_o", int'(overflow_o), int'(mOvf));
      if (fire_o) fireLog.push_back(int'(fireCh_o));
      if (rstn_i) begin
        for (int c = 0; c < CH; c++) begin
          inc    = evt_i[c];
          dcr    = (mPhase == 1) && (mFireCh == c);
          setNow = inc && !dcr && (mCnt[c] == CMAX);
          if (inc && !dcr && mCnt[c] < CMAX) mCnt[c]++;
          else if (dcr && !inc)              mCnt[c]--;
          if (setNow)                mOvf[c] = 1'b1;
          else if (overflowClr_i[c]) mOvf[c] = 1'b0;
        end
        if (mPhase == 0) begin
          if (ready_i && pend != '0) begin
            got = 1'b0;
            sel = 0;
            for (int k = 1; k <= CH; k++) begin
              ch = (mLast + k) % CH;
              if (!got && pend[ch]) begin
                got = 1'b1;
                sel = ch;
              end
            end
            mFireCh = sel;
            mLast   = sel;
            mPhase  = 1;
          end
        end else if (mPhase == 1) begin
          mPhase = 2;
        end else if (!ready_i) begin
          mPhase = 0;
        end
      end
    end
  end

  // Apply inputs for the current cycle, then move to 1 time unit after the next rising edge.
  // The auto downstream drops ready the cycle after a fire and raises it 4 cycles later.
  task automatic tick(input logic [CH-1:0] e, input logic [CH-1:0] c);
    evt_i         = e;
    overflowClr_i = c;
    if (dsAuto) begin
      if (prevFire) begin
        readyQ = 1'b0;
        dsHold = 4;
      end else if (dsHold > 0) begin
        dsHold--;
        if (dsHold == 0) readyQ = 1'b1;
      end
    end
    ready_i  = readyQ;
    prevFire = fire_o;
    @(posedge clk);
    #1;
    evt_i         = '0;
    overflowClr_i = '0;
  endtask

  task automatic setAuto();
    dsAuto   = 1'b1;
    readyQ   = 1'b1;
    dsHold   = 0;
    prevFire = 1'b0;
  endtask

  task automatic setManual(input logic r);
    dsAuto = 1'b0;
    readyQ = r;
  endtask

  initial begin : stim
    int n0;
    int rr[6];
    rr = '{0, 1, 3, 0, 1, 3};
    rstn_i        = 1'b0;
    evt_i         = '0;
    overflowClr_i = '0;
    ready_i       = 1'b0;
    dsAuto        = 1'b0;
    readyQ        = 1'b0;
    dsHold        = 0;
    prevFire      = 1'b0;

    // Reset held with random inputs.
    repeat (5) begin
      @(posedge clk);
      #1;
      evt_i         = CH'($urandom_range(15, 0));
      overflowClr_i = CH'($urandom_range(15, 0));
      ready_i       = 1'($urandom_range(1, 0));
    end
    chk("reset fire_o", int'(fire_o), 0);
    chk("reset fireCh_o", int'(fireCh_o), 0);
    chk("reset pending_o", int'(pending_o), 0);
    chk("reset overflow_o", int'(overflow_o), 0);

    evt_i         = '0;
    overflowClr_i = '0;
    setAuto();
    ready_i = 1'b1;
    rstn_i  = 1'b1;
    n0 = fireLog.size();
    repeat (20) tick('0, '0);
    chk("idle fire count", fireLog.size() - n0, 0);

    // Single event: pending at t+1, fire at t+2.
    n0 = fireLog.size();
    tick(4'b0001, '0);
    chk("single pending t+1", int'(pending_o), 1);
    chk("single fire t+1", int'(fire_o), 0);
    tick('0, '0);
    chk("single fire t+2", int'(fire_o), 1);
    chk("single fireCh t+2", int'(fireCh_o), 0);
    repeat (20) tick('0, '0);
    chk("single fire count", fireLog.size() - n0, 1);
    chk("single drained", int'(pending_o), 0);

    // Backlog of five on channel 2.
    setManual(1'b0);
    repeat (5) tick(4'b0100, '0);
    chk("backlog pending", int'(pending_o), 4);
    n0 = fireLog.size();
    setAuto();
    repeat (45) tick('0, '0);
    chk("backlog fire count", fireLog.size() - n0, 5);
    for (int i = n0; i < fireLog.size(); i++) chk("backlog fireCh", fireLog[i], 2);
    chk("backlog overflow", int'(overflow_o), 0);
    chk("backlog drained", int'(pending_o), 0);

    // Event on channel 0 in its own FIRE cycle stays queued.
    n0 = fireLog.size();
    tick(4'b0001, '0);
    tick('0, '0);
    chk("simul fire", int'(fire_o), 1);
    chk("simul fireCh", int'(fireCh_o), 0);
    tick(4'b0001, '0);
    chk("simul pending after", int'(pending_o), 1);
    chk("simul model cnt0", mCnt[0], 1);
    repeat (25) tick('0, '0);
    chk("simul fire count", fireLog.size() - n0, 2);
    chk("simul drained", int'(pending_o), 0);

    // Saturation and sticky overflow on channel 1.
    setManual(1'b0);
    repeat (17) tick(4'b0010, '0);
    chk("ovf flag set", int'(overflow_o), 2);
    chk("ovf pending", int'(pending_o), 2);
    chk("ovf model cnt1", mCnt[1], 15);
    tick(4'b0010, 4'b0010);
    chk("ovf set beats clear", int'(overflow_o), 2);
    tick('0, 4'b0010);
    chk("ovf cleared", int'(overflow_o), 0);
    chk("ovf clear keeps count", int'(pending_o), 2);
    n0 = fireLog.size();
    setAuto();
    repeat (110) tick('0, '0);
    chk("ovf fire count", fireLog.size() - n0, 15);
    chk("ovf drained", int'(pending_o), 0);

    // Fresh reset so the round-robin search starts at channel 0.
    rstn_i = 1'b0;
    repeat (2) tick('0, '0);
    rstn_i = 1'b1;
    setManual(1'b0);
    repeat (2) tick(4'b1011, '0);
    chk("rr pending", int'(pending_o), 11);
    n0 = fireLog.size();
    setAuto();
    repeat (50) tick('0, '0);
    chk("rr fire count", fireLog.size() - n0, 6);
    for (int i = 0; i < 6; i++) begin
      if (n0 + i < fireLog.size()) chk("rr fireCh order", fireLog[n0 + i], rr[i]);
    end

    // Reset while waiting discards the backlog.
    setManual(1'b1);
    tick(4'b0001, '0);
    tick(4'b0001, '0);
    chk("midrst fire", int'(fire_o), 1);
    tick('0, '0);
    chk("midrst wait pending", int'(pending_o), 1);
    chk("midrst wait fire", int'(fire_o), 0);
    tick('0, '0);
    rstn_i = 1'b0;
    #1;
    chk("midrst async pending", int'(pending_o), 0);
    chk("midrst async fire", int'(fire_o), 0);
    tick('0, '0);
    rstn_i = 1'b1;
    n0 = fireLog.size();
    repeat (15) tick('0, '0);
    chk("midrst no fire", fireLog.size() - n0, 0);
    chk("midrst pending", int'(pending_o), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
